// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: default widths, ALU opcodes and
// the all-zero bubble control word.
package cpu_pkg;

   localparam int unsigned DATA_W_DFLT  = 32;
   localparam int unsigned RA_W_DFLT    = 5;
   localparam int unsigned ALUOP_W_DFLT = 4;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLT = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7,
      ALU_SRA = 4'd8,
      ALU_NOR = 4'd9,
      ALU_LUI = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic alusrc;
   } ctrl_t;

   // A bubble carries no side effects: no register write, no memory access.
   localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// Load-use hazard detection: the instruction in ID needs a register that the
// load currently in EX has not yet fetched from memory.
module load_use_detect
   import cpu_pkg::*;
#(
   parameter int unsigned RA_W = RA_W_DFLT
) (
   input  logic            ex_valid,
   input  logic            ex_memread,
   input  logic [RA_W-1:0] ex_rt,
   input  logic            id_valid,
   input  logic            id_uses_rs,
   input  logic            id_uses_rt,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   output logic            lu
);

   logic rs_hit;
   logic rt_hit;

   // A load into $0 never produces a value, so it can never cause a hazard.
   always_comb begin
      rs_hit = id_uses_rs && (id_rs == ex_rt);
      rt_hit = id_uses_rt && (id_rt == ex_rt);
      lu     = ex_valid && ex_memread && (ex_rt != '0) && (rs_hit || rt_hit) && id_valid;
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// mul/div busy hold and a saturating count of inserted load-use bubbles.
module id_ex_pipe
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DFLT,
   parameter int unsigned RA_W    = RA_W_DFLT,
   parameter int unsigned ALUOP_W = ALUOP_W_DFLT,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [RA_W-1:0]    id_rs,
   input  logic [RA_W-1:0]    id_rt,
   input  logic [RA_W-1:0]    id_rd,
   input  logic               id_uses_rs,
   input  logic               id_uses_rt,
   input  logic [DATA_W-1:0]  id_rdata1,
   input  logic [DATA_W-1:0]  id_rdata2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [DATA_W-1:0]  id_pc,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_memtoreg,
   input  logic               id_alusrc,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic               branch_flush,
   input  logic               ex_busy,
   output logic               ex_valid,
   output logic [RA_W-1:0]    ex_rs,
   output logic [RA_W-1:0]    ex_rt,
   output logic [RA_W-1:0]    ex_rd,
   output logic [DATA_W-1:0]  ex_rdata1,
   output logic [DATA_W-1:0]  ex_rdata2,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [DATA_W-1:0]  ex_pc,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_memtoreg,
   output logic               ex_alusrc,
   output logic [ALUOP_W-1:0] ex_aluop,
   output logic               stall_if,
   output logic [CNT_W-1:0]   bubble_cnt
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  lu;
   logic  load_bubble;
   logic  count_bubble;

   load_use_detect #(
      .RA_W (RA_W)
   ) u_lu (
      .ex_valid   (ex_valid),
      .ex_memread (ex_ctrl.memread),
      .ex_rt      (ex_rt),
      .id_valid   (id_valid),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .lu         (lu)
   );

   // Pack ID control, decide bubble/count and the fetch stall.
   always_comb begin
      id_ctrl.regwrite = id_regwrite;
      id_ctrl.memread  = id_memread;
      id_ctrl.memwrite = id_memwrite;
      id_ctrl.memtoreg = id_memtoreg;
      id_ctrl.alusrc   = id_alusrc;
      load_bubble      = branch_flush || lu || !id_valid;
      count_bubble     = !ex_busy && !branch_flush && lu;
      stall_if         = ex_busy || (lu && !branch_flush);
   end

   // Pipeline register: busy holds, otherwise bubble or ID contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_rs     <= '0;
         ex_rt     <= '0;
         ex_rd     <= '0;
         ex_rdata1 <= '0;
         ex_rdata2 <= '0;
         ex_imm    <= '0;
         ex_pc     <= '0;
         ex_ctrl   <= BUBBLE;
         ex_aluop  <= '0;
      end else if (!ex_busy) begin
         if (load_bubble) begin
            ex_valid  <= 1'b0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
            ex_ctrl   <= BUBBLE;
            ex_aluop  <= '0;
         end else begin
            ex_valid  <= 1'b1;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc     <= id_pc;
            ex_ctrl   <= id_ctrl;
            ex_aluop  <= id_aluop;
         end
      end
   end

   // Saturating count of load-use bubbles (flush and busy take precedence).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (count_bubble && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

   // Unpack registered control onto the EX ports.
   always_comb begin
      ex_regwrite = ex_ctrl.regwrite;
      ex_memread  = ex_ctrl.memread;
      ex_memwrite = ex_ctrl.memwrite;
      ex_memtoreg = ex_ctrl.memtoreg;
      ex_alusrc   = ex_ctrl.alusrc;
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: a driver applies one directed vector per cycle and
// queues the hand-derived EX state / stall / count expected in that cycle;
// a monitor pops and compares on every falling edge.
module tb_id_ex_pipe;

   localparam int NV = 59;

   typedef struct {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic        urs, urt;
      logic [31:0] d;
      logic [4:0]  ctl;   // {regwrite, memread, memwrite, memtoreg, alusrc}
      logic [3:0]  aluop;
      logic        flush, busy;
   } in_t;

   typedef struct {
      int         cyc;
      int         src;    // vector index expected in EX, -1 for a bubble
      logic       stall;
      logic [3:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt;
   logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc;
   logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
   logic [3:0]  id_aluop;
   logic        branch_flush, ex_busy;
   logic        ex_valid;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
   logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
   logic [3:0]  ex_aluop;
   logic        stall_if;
   logic [3:0]  bubble_cnt;

   in_t  vec [NV];
   exp_t q [$];
   int   n_checks = 0;
   int   n_fails  = 0;

   id_ex_pipe #(
      .DATA_W  (32),
      .RA_W    (5),
      .ALUOP_W (4),
      .CNT_W   (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_rdata1    (id_rdata1),
      .id_rdata2    (id_rdata2),
      .id_imm       (id_imm),
      .id_pc        (id_pc),
      .id_regwrite  (id_regwrite),
      .id_memread   (id_memread),
      .id_memwrite  (id_memwrite),
      .id_memtoreg  (id_memtoreg),
      .id_alusrc    (id_alusrc),
      .id_aluop     (id_aluop),
      .branch_flush (branch_flush),
      .ex_busy      (ex_busy),
      .ex_valid     (ex_valid),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_rd        (ex_rd),
      .ex_rdata1    (ex_rdata1),
      .ex_rdata2    (ex_rdata2),
      .ex_imm       (ex_imm),
      .ex_pc        (ex_pc),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_memwrite  (ex_memwrite),
      .ex_memtoreg  (ex_memtoreg),
      .ex_alusrc    (ex_alusrc),
      .ex_aluop     (ex_aluop),
      .stall_if     (stall_if),
      .bubble_cnt   (bubble_cnt)
   );

   always #5 clk = ~clk;

   function automatic in_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic urs, logic urt, logic [31:0] d, logic [4:0] ctl,
                              logic [3:0] op, logic fl, logic bz);
      in_t t;
      t.valid = v;  t.rs = rs;   t.rt = rt;   t.rd = rd;
      t.urs = urs;  t.urt = urt; t.d = d;     t.ctl = ctl;
      t.aluop = op; t.flush = fl; t.busy = bz;
      return t;
   endfunction

   function automatic logic [31:0] d2(logic [31:0] d);
      return d ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] dimm(logic [31:0] d);
      return d + 32'h10;
   endfunction

   function automatic logic [31:0] dpc(int k);
      return 32'h1000 + 32'(k * 4);
   endfunction

   task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL cyc%0d %s actual=%h required=%h", cyc, name, act, req);
      end
   endtask

   task automatic apply(int k);
      in_t v;
      v = vec[k];
      id_valid     = v.valid;
      id_rs        = v.rs;
      id_rt        = v.rt;
      id_rd        = v.rd;
      id_uses_rs   = v.urs;
      id_uses_rt   = v.urt;
      id_rdata1    = v.d;
      id_rdata2    = d2(v.d);
      id_imm       = dimm(v.d);
      id_pc        = dpc(k);
      {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc} = v.ctl;
      id_aluop     = v.aluop;
      branch_flush = v.flush;
      ex_busy      = v.busy;
   endtask

   task automatic push(int k, int src, logic st, logic [3:0] c);
      exp_t e;
      e.cyc = k; e.src = src; e.stall = st; e.cnt = c;
      q.push_back(e);
   endtask

   // Monitor: compare full visible EX state against the queued expectation.
   initial begin
      exp_t e;
      in_t  v;
      logic [31:0] r1, r2, ri, rp;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.src < 0) begin
               v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
               r1 = '0; r2 = '0; ri = '0; rp = '0;
            end else begin
               v = vec[e.src];
               r1 = v.d; r2 = d2(v.d); ri = dimm(v.d); rp = dpc(e.src);
            end
            chk("ex_valid",  e.cyc, 32'(ex_valid),  32'(v.valid));
            chk("ex_rs",     e.cyc, 32'(ex_rs),     32'(v.rs));
            chk("ex_rt",     e.cyc, 32'(ex_rt),     32'(v.rt));
            chk("ex_rd",     e.cyc, 32'(ex_rd),     32'(v.rd));
            chk("ex_rdata1", e.cyc, ex_rdata1,      r1);
            chk("ex_rdata2", e.cyc, ex_rdata2,      r2);
            chk("ex_imm",    e.cyc, ex_imm,         ri);
            chk("ex_pc",     e.cyc, ex_pc,          rp);
            chk("ex_ctrl",   e.cyc,
                32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc}),
                32'(v.ctl));
            chk("ex_aluop",  e.cyc, 32'(ex_aluop),  32'(v.aluop));
            chk("stall_if",  e.cyc, 32'(stall_if),  32'(e.stall));
            chk("bubble_cnt", e.cyc, 32'(bubble_cnt), 32'(e.cnt));
         end
      end
   end

   // busy together with flush is an illegal upstream combination.
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         assert (!(ex_busy && branch_flush))
         else begin
            n_fails++;
            $display("FAIL illegal_busy_flush actual=1 required=0");
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Driver and directed expectations.
   initial begin
      int k;
      // lw = {rw,mr,mw,mt,as} 11011, R-type = 10000
      vec[0]  = mk(1, 3, 4, 5, 1, 1, 32'h11, 5'b10000, 2, 0, 0);
      vec[1]  = mk(1, 2, 8, 8, 1, 0, 32'h22, 5'b11011, 0, 0, 0);
      vec[2]  = mk(1, 8, 9, 10, 1, 1, 32'h33, 5'b10000, 2, 0, 0);
      vec[3]  = mk(1, 8, 9, 10, 1, 1, 32'h33, 5'b10000, 2, 0, 0);
      vec[4]  = mk(1, 1, 0, 0, 1, 0, 32'h44, 5'b11011, 0, 0, 0);
      vec[5]  = mk(1, 0, 0, 6, 1, 1, 32'h55, 5'b10000, 2, 0, 0);
      vec[6]  = mk(1, 3, 8, 8, 1, 0, 32'h66, 5'b11011, 0, 0, 0);
      vec[7]  = mk(1, 1, 8, 7, 1, 0, 32'h77, 5'b10000, 2, 0, 0);
      vec[8]  = mk(1, 4, 9, 9, 1, 0, 32'h88, 5'b11011, 0, 0, 0);
      vec[9]  = mk(1, 9, 2, 3, 1, 1, 32'h99, 5'b10000, 2, 1, 0);
      vec[10] = mk(1, 5, 6, 7, 1, 1, 32'hAA, 5'b00101, 3, 0, 0);
      vec[11] = mk(1, 1, 2, 3, 1, 1, 32'hB1, 5'b10000, 4, 0, 1);
      vec[12] = mk(1, 11, 12, 13, 1, 1, 32'hB2, 5'b11111, 7, 0, 1);
      vec[13] = mk(1, 8, 8, 8, 1, 1, 32'hB3, 5'b11011, 1, 0, 1);
      vec[14] = mk(1, 12, 13, 14, 1, 1, 32'hC4, 5'b10000, 5, 0, 0);
      vec[15] = mk(0, 7, 8, 20, 1, 1, 32'hD5, 5'b11111, 6, 0, 0);
      vec[16] = mk(1, 3, 8, 8, 1, 0, 32'hE6, 5'b11011, 0, 0, 0);
      for (int j = 0; j < 20; j++) begin
         vec[17 + 2*j] = mk(1, 8, 8, 8, 1, 0, 32'h100 + 32'(17 + 2*j), 5'b11011, 0, 0, 0);
         vec[18 + 2*j] = mk(1, 8, 8, 8, 1, 0, 32'h100 + 32'(18 + 2*j), 5'b11011, 0, 0, 0);
      end
      vec[57] = mk(1, 3, 8, 8, 1, 0, 32'hF7, 5'b11011, 0, 0, 0);
      vec[58] = mk(1, 8, 2, 9, 1, 1, 32'hF8, 5'b10000, 2, 0, 0);

      rst_n = 1'b0;
      apply(0);
      id_valid = 1'b0; branch_flush = 1'b0; ex_busy = 1'b0;
      id_memread = 1'b0; id_regwrite = 1'b0;
      #3;
      chk("reset_ex_valid", -1, 32'(ex_valid), 32'd0);
      chk("reset_ex_rd",    -1, 32'(ex_rd), 32'd0);
      chk("reset_ex_regwrite", -1, 32'(ex_regwrite), 32'd0);
      chk("reset_bubble_cnt", -1, 32'(bubble_cnt), 32'd0);
      #10 rst_n = 1'b1;   // t=13, away from the edge at 15

      for (k = 0; k < NV; k++) begin
         @(posedge clk);
         #1;
         apply(k);
         case (k)
            0:  push(k, -1, 0, 0);
            1:  push(k, 0, 0, 0);
            2:  push(k, 1, 1, 0);
            3:  push(k, -1, 0, 1);
            4:  push(k, 3, 0, 1);
            5:  push(k, 4, 0, 1);
            6:  push(k, 5, 0, 1);
            7:  push(k, 6, 0, 1);
            8:  push(k, 7, 0, 1);
            9:  push(k, 8, 0, 1);
            10: push(k, -1, 0, 1);
            11: push(k, 10, 1, 1);
            12: push(k, 10, 1, 1);
            13: push(k, 10, 1, 1);
            14: push(k, 10, 0, 1);
            15: push(k, 14, 0, 1);
            16: push(k, -1, 0, 1);
            57: push(k, 56, 0, 15);
            58: push(k, 57, 1, 15);
            default: begin
               if (k % 2 == 1)
                  push(k, k - 1, 1, 4'((1 + (k - 17) / 2) > 15 ? 15 : 1 + (k - 17) / 2));
               else
                  push(k, -1, 0, 4'((2 + (k - 18) / 2) > 15 ? 15 : 2 + (k - 18) / 2));
            end
         endcase
      end

      // Reset in the middle of a stall: clears immediately, no edge needed.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ex_valid",   58, 32'(ex_valid), 32'd0);
      chk("midrst_ex_rs",      58, 32'(ex_rs), 32'd0);
      chk("midrst_ex_rt",      58, 32'(ex_rt), 32'd0);
      chk("midrst_ex_rd",      58, 32'(ex_rd), 32'd0);
      chk("midrst_ex_rdata1",  58, ex_rdata1, 32'd0);
      chk("midrst_ex_pc",      58, ex_pc, 32'd0);
      chk("midrst_ex_ctrl",    58,
          32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc}), 32'd0);
      chk("midrst_ex_aluop",   58, 32'(ex_aluop), 32'd0);
      chk("midrst_bubble_cnt", 58, 32'(bubble_cnt), 32'd0);
      chk("midrst_stall_if",   58, 32'(stall_if), 32'd0);
      chk("queue_drained",     58, 32'(q.size()), 32'd0);
      #2;
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
